way_data_writer: RTL

Write-side datapath between the cache controller and the way array. Performs single-word CPU write hits and full-line refills from the memory side. Latches a one-hot target-way vector and drives a registered, one-hot write strobe, word offset and write data to every way. Signals completion back to the controller. It is the write counterpart of the way read-mux, which returns hit data to the CPU.

---
 rtl/way_data_writer_pkg.sv | 31 +++
 rtl/way_data_writer_onehot.sv | 22 ++
 rtl/way_data_writer.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/way_data_writer_pkg.sv
// -----------------------------------------------------------------------------
// way_data_writer_pkg
// Shared cache-side definitions for the way write path (and the read side):
//   - write-path FSM state encoding
//   - word-offset width derivation from the line size
//   - one-hot check on a way-select vector
// -----------------------------------------------------------------------------
package way_data_writer_pkg;

  // Widest way-select vector the shared one-hot helper can check.
  // Narrower vectors are zero-extended, which does not change the result.
  localparam int WAY_VEC_MAX = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORD = 2'd1,
    FILL = 2'd2
  } way_wr_state_e;

  // Number of bits needed to address a word inside a line.
  // Clamped to 1 so a degenerate line size still yields a legal vector.
  function automatic int way_offset_width(input int words_per_line);
    return (words_per_line < 2) ? 1 : $clog2(words_per_line);
  endfunction

  // True when exactly one bit of vec is set.
  function automatic logic way_is_onehot(input logic [WAY_VEC_MAX-1:0] vec);
    return (vec != '0) && ((vec & (vec - WAY_VEC_MAX'(1))) == '0);
  endfunction

endpackage

// File: rtl/way_data_writer_onehot.sv
// -----------------------------------------------------------------------------
// way_onehot_check
// Combinational validity check on a way-select vector: o_onehot is high when
// exactly one bit of i_vec is set. Kept as its own module so controller-side
// checkers can instantiate the same logic the write path uses.
// -----------------------------------------------------------------------------
module way_onehot_check
  import way_data_writer_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_onehot
);

  if (WIDTH > WAY_VEC_MAX) begin : g_width_check
    $error("way_onehot_check: WIDTH exceeds WAY_VEC_MAX");
  end

  assign o_onehot = way_is_onehot(WAY_VEC_MAX'(i_vec));

endmodule

// File: rtl/way_data_writer.sv
// -----------------------------------------------------------------------------
// way_data_writer
// Write-side datapath between the cache controller and the way array.
// Handles single-word CPU write hits and full-line refills from memory, and
// drives a registered one-hot write strobe, word offset and data to all ways.
//
// Optional feature macro: WAY_WRITER_BYTE_MASK_EN
//   defined   : adds i_req_byte_en / o_way_byte_en. Word writes forward the
//               request mask, fills force all ones, and an all-zero mask on a
//               word write completes (o_done) without strobing any way.
//   undefined : every write is a full word; the mask ports do not exist.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | waiting for a request; o_req_ready high unless a done is showing
// WORD  | single-word write strobe on the outputs, o_done high this cycle
// FILL  | accepting fill beats; each beat is written the following cycle
//
// The last fill beat sends the FSM straight back to IDLE, so its write cycle
// is spent in IDLE with o_done high. o_req_ready is masked by the registered
// done so that no request is taken in any done cycle.
// -----------------------------------------------------------------------------
module way_data_writer
  import way_data_writer_pkg::*;
#(
  parameter int NUM_WAYS       = 512,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int WORDS_PER_LINE = 16,
  parameter int OFFSET_WIDTH   = way_offset_width(WORDS_PER_LINE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // controller request
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic                      i_req_fill,
  input  logic [NUM_WAYS-1:0]       i_req_target_way,
  input  logic [OFFSET_WIDTH-1:0]   i_req_offset,
  input  logic [DATA_WIDTH-1:0]     i_req_data,
`ifdef WAY_WRITER_BYTE_MASK_EN
  input  logic [DATA_WIDTH/8-1:0]   i_req_byte_en,
  output logic [DATA_WIDTH/8-1:0]   o_way_byte_en,
`endif
  // memory-side fill beats
  input  logic                      i_fill_valid,
  output logic                      o_fill_ready,
  input  logic [DATA_WIDTH-1:0]     i_fill_data,
  // way array write port
  output logic [NUM_WAYS-1:0]       o_way_we,
  output logic [OFFSET_WIDTH-1:0]   o_way_offset,
  output logic [DATA_WIDTH-1:0]     o_way_data,
  // completion
  output logic                      o_done,
  output logic                      o_err
);

  if ((WORDS_PER_LINE < 2) || ((WORDS_PER_LINE & (WORDS_PER_LINE - 1)) != 0)) begin : g_wpl_check
    $error("way_data_writer: WORDS_PER_LINE must be a power of two >= 2");
  end

  if (ADDRESS_WIDTH <= OFFSET_WIDTH) begin : g_addr_check
    $error("way_data_writer: ADDRESS_WIDTH too small for the word offset");
  end

  localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(WORDS_PER_LINE - 1);

  way_wr_state_e              r_state;
  way_wr_state_e              w_state_next;

  logic [NUM_WAYS-1:0]        r_target;
  logic [OFFSET_WIDTH-1:0]    r_beat_cnt;
  logic [NUM_WAYS-1:0]        r_way_we;
  logic [OFFSET_WIDTH-1:0]    r_way_offset;
  logic [DATA_WIDTH-1:0]      r_way_data;
  logic                       r_done;
  logic                       r_err;

  logic                       w_target_ok;
  logic                       w_req_accept;
  logic                       w_fill_beat;
  logic                       w_last_beat;
  logic [NUM_WAYS-1:0]        w_word_we;

`ifdef WAY_WRITER_BYTE_MASK_EN
  logic [DATA_WIDTH/8-1:0]    r_way_byte_en;

  // A word write with an empty mask still completes but touches no way.
  assign w_word_we = (i_req_byte_en == '0) ? '0 : i_req_target_way;
  assign o_way_byte_en = r_way_byte_en;
`else
  assign w_word_we = i_req_target_way;
`endif

  way_onehot_check #(
    .WIDTH (NUM_WAYS)
  ) u_target_check (
    .i_vec    (i_req_target_way),
    .o_onehot (w_target_ok)
  );

  // Next-state decode plus the handshake outputs, all derived from state.
  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 1'b0;
    o_fill_ready = 1'b0;
    w_req_accept = 1'b0;
    w_fill_beat  = 1'b0;
    w_last_beat  = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready  = !r_done;
        w_req_accept = i_req_valid && !r_done;
        if (w_req_accept && w_target_ok) begin
          w_state_next = i_req_fill ? FILL : WORD;
        end
      end
      WORD: begin
        w_state_next = IDLE;
      end
      FILL: begin
        o_fill_ready = 1'b1;
        w_fill_beat  = i_fill_valid;
        w_last_beat  = i_fill_valid && (r_beat_cnt == LAST_OFFSET);
        if (w_last_beat) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // State, beat counter and registered way-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_target      <= '0;
      r_beat_cnt    <= '0;
      r_way_we      <= '0;
      r_way_offset  <= '0;
      r_way_data    <= '0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
`ifdef WAY_WRITER_BYTE_MASK_EN
      r_way_byte_en <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_way_we <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;

      if (w_req_accept) begin
        if (!w_target_ok) begin
          r_err <= 1'b1;
        end else begin
          r_target   <= i_req_target_way;
          r_beat_cnt <= '0;
          if (!i_req_fill) begin
            r_way_we      <= w_word_we;
            r_way_offset  <= i_req_offset;
            r_way_data    <= i_req_data;
            r_done        <= 1'b1;
`ifdef WAY_WRITER_BYTE_MASK_EN
            r_way_byte_en <= i_req_byte_en;
`endif
          end
        end
      end

      if (w_fill_beat) begin
        r_way_we      <= r_target;
        r_way_offset  <= r_beat_cnt;
        r_way_data    <= i_fill_data;
        r_beat_cnt    <= r_beat_cnt + OFFSET_WIDTH'(1);
        r_done        <= w_last_beat;
`ifdef WAY_WRITER_BYTE_MASK_EN
        r_way_byte_en <= '1;
`endif
      end
    end
  end

  assign o_way_we     = r_way_we;
  assign o_way_offset = r_way_offset;
  assign o_way_data   = r_way_data;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
